// File: rtl/mask_refresh_sched.sv
// mask_refresh_sched: round-robin share of one mul_add_p refresh datapath among N_REQ requesters.
// Ports: req_valid/req_ready/req_data  - per-requester state to refresh (one-hot grant)
//        rnd_valid/rnd_ready/rnd_data  - RNG word, consumed once per transaction
//        cfg_we/cfg_M/cfg_err          - matrix register load; cfg_err pulses on rejection
//        out_valid/out_ready/out_data/out_id - refreshed state and owning requester
//        busy, tx_cnt                  - FSM not IDLE, completed transaction count
// Optional: MASK_REFRESH_ZEROIZE_EN clears data_q/out_q after each result and masks out_data.
package mask_refresh_pkg;
  localparam int S_W = 32;
  localparam int R_W = 8;
  typedef logic [S_W-1:0] state_t;
  typedef logic [R_W-1:0] red_poly_t;
  typedef logic [R_W-1:0][S_W-1:0] dn_matrix_t;
  function automatic state_t mul_P(red_poly_t r, dn_matrix_t M);
    mul_P = '0;
    for (int i = 0; i < R_W; i++) mul_P ^= r[i] ? M[i] : '0;
  endfunction
endpackage

module mul_add_p
  import mask_refresh_pkg::*;
(
  input  state_t     in,
  input  red_poly_t  r,
  input  dn_matrix_t M,
  output state_t     out
);
  assign out = in ^ mul_P(r, M);
endmodule

module mask_refresh_sched
  import mask_refresh_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  state_t [N_REQ-1:0]    req_data,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  input  red_poly_t             rnd_data,
  input  logic                  cfg_we,
  input  dn_matrix_t            cfg_M,
  output logic                  cfg_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output state_t                out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      tx_cnt
);
  typedef enum logic [1:0] {IDLE, RND, OUT} st_e;
  st_e              st_q;
  logic [ID_W-1:0]  ptr_q, id_q, gnt, idx;
  state_t           data_q, out_q, mul_out;
  dn_matrix_t       m_q;
  logic             cfg_err_q, any_req;
  logic [CNT_W-1:0] cnt_q;

  mul_add_p u_mul (.in(data_q), .r(rnd_data), .M(m_q), .out(mul_out));

  // descending scan so the last hit is the first requester at or after ptr
  always_comb begin
    gnt = ptr_q;
    idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (req_valid[idx]) gnt = idx;
    end
  end

  assign any_req   = |req_valid;
  assign req_ready = (st_q == IDLE && any_req) ? (N_REQ'(1) << gnt) : '0;
  assign rnd_ready = st_q == RND;
  assign out_valid = st_q == OUT;
  assign busy      = st_q != IDLE;
  assign out_id    = id_q;
  assign tx_cnt    = cnt_q;
  assign cfg_err   = cfg_err_q;
`ifdef MASK_REFRESH_ZEROIZE_EN
  assign out_data  = out_valid ? out_q : '0;
`else
  assign out_data  = out_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      data_q    <= '0;
      out_q     <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && (st_q != IDLE || any_req);
      if (cfg_we && st_q == IDLE && !any_req) m_q <= cfg_M;
      case (st_q)
        IDLE: if (any_req) begin
          data_q <= req_data[gnt];
          id_q   <= gnt;
          st_q   <= RND;
        end
        RND: if (rnd_valid) begin
          out_q <= mul_out;
          st_q  <= OUT;
        end
        OUT: if (out_ready) begin
          ptr_q <= (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + 1'b1;
          cnt_q <= cnt_q + 1'b1;
          st_q  <= IDLE;
`ifdef MASK_REFRESH_ZEROIZE_EN
          data_q <= '0;
          out_q  <= '0;
`endif
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mask_refresh_sched.sv
// tb_mask_refresh_sched: directed scoreboard bench for mask_refresh_sched.
module tb_mask_refresh_sched;
  import mask_refresh_pkg::*;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0]       req_ready;
  state_t [3:0]     req_data = '0;
  logic             rnd_valid = 1'b0;
  logic             rnd_ready;
  red_poly_t        rnd_data = '0;
  logic             cfg_we = 1'b0;
  dn_matrix_t       cfg_M = '0;
  logic             cfg_err;
  logic             out_valid;
  logic             out_ready = 1'b0;
  state_t           out_data;
  logic [1:0]       out_id;
  logic             busy;
  logic [15:0]      tx_cnt;
  mask_refresh_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .cfg_we(cfg_we), .cfg_M(cfg_M), .cfg_err(cfg_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .busy(busy), .tx_cnt(tx_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] id;
    state_t     data;
  } exp_t;
  exp_t        sb[$];
  int          grants[$];
  int          checks = 0;
  int          errors = 0;
  int          mst = 0;
  int          mptr = 0;
  logic [15:0] cnt_ref = '0;
  dn_matrix_t  m_ref = '0;
  logic        err_ref = 1'b0;
  state_t      last_out = '0;
  logic [1:0]  last_id = '0;
  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction
  function automatic state_t mul_ref(red_poly_t r, dn_matrix_t m);
    state_t s;
    for (int j = 0; j < S_W; j++) begin
      s[j] = 1'b0;
      for (int i = 0; i < R_W; i++) s[j] ^= r[i] & m[i][j];
    end
    return s;
  endfunction
  function automatic dn_matrix_t rand_m();
    dn_matrix_t m;
    for (int i = 0; i < R_W; i++) m[i] = $urandom;
    return m;
  endfunction
  task automatic step();
    int g;
    logic [3:0] exp_rr;
    exp_t e;
    #1;
    chk("cfg_err", cfg_err, err_ref);
    chk("tx_cnt", tx_cnt, cnt_ref);
    chk("busy", busy, (mst != 0));
    chk("rnd_ready", rnd_ready, (mst == 1));
    chk("out_valid", out_valid, (mst == 2));
    chk("out_id", out_id, last_id);
    g = -1;
    if (mst == 0)
      for (int k = 0; k < 4; k++)
        if (g < 0 && req_valid[(mptr + k) % 4]) g = (mptr + k) % 4;
    exp_rr = (g >= 0) ? 4'(1 << g) : 4'h0;
    chk("req_ready", req_ready, exp_rr);
    if (mst == 2) begin
      chk("sb_id", out_id, sb[0].id);
      chk("sb_data", out_data, sb[0].data);
    end else begin
`ifdef MASK_REFRESH_ZEROIZE_EN
      chk("out_data_idle", out_data, state_t'(0));
`else
      chk("out_data_idle", out_data, last_out);
`endif
    end
    err_ref = cfg_we && (mst != 0 || req_valid != 0);
    if (cfg_we && !err_ref) m_ref = cfg_M;
    case (mst)
      0: if (g >= 0) begin
        e.id = 2'(g);
        e.data = req_data[g];
        sb.push_back(e);
        grants.push_back(g);
        last_id = 2'(g);
        mst = 1;
      end
      1: if (rnd_valid) begin
        e = sb.pop_back();
        e.data ^= mul_ref(rnd_data, m_ref);
        sb.push_back(e);
        last_out = e.data;
        mst = 2;
      end
      default: if (out_ready) begin
        void'(sb.pop_front());
        mptr = (int'(last_id) + 1) % 4;
        cnt_ref++;
`ifdef MASK_REFRESH_ZEROIZE_EN
        last_out = '0;
`endif
        mst = 0;
      end
    endcase
    if (rst) begin
      mst = 0; mptr = 0; cnt_ref = '0; m_ref = '0; err_ref = 1'b0;
      last_out = '0; last_id = '0; sb.delete();
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    step();
    cfg_we = 1'b1; cfg_M = rand_m();
    step();
    cfg_we = 1'b0;
    step();
    req_valid = 4'b0001; req_data = '0;
    step();
    req_valid = '0; rnd_valid = 1'b1; rnd_data = '0;
    step();
    rnd_valid = 1'b0; out_ready = 1'b1;
    chk("t2_out_valid", out_valid, 1'b1);
    chk("t2_out_data", out_data, state_t'(0));
    step();
    out_ready = 1'b0;
    step();
    chk("t_single_cnt", tx_cnt, 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cfg_we = 1'b1; cfg_M = rand_m();
    step();
    cfg_we = 1'b0;
    grants.delete();
    req_valid = 4'hF; rnd_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < 4; i++) req_data[i] = $urandom;
      rnd_data = red_poly_t'($urandom);
      step();
    end
    req_valid = '0; rnd_valid = 1'b0; out_ready = 1'b0;
    chk("rr_grants", grants.size(), 5);
    for (int i = 0; i < 5; i++) if (i < grants.size()) chk("rr_order", grants[i], exp_order[i]);
    chk("rr_cnt", tx_cnt, 16'd5);
    step();
    req_valid = 4'b0100; req_data[2] = 32'hDEAD_BEEF;
    step();
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      cfg_we = (c == 3); cfg_M = rand_m();
      step();
    end
    cfg_we = 1'b0;
    rnd_valid = 1'b1; rnd_data = 8'hA5;
    step();
    rnd_valid = 1'b1; req_valid = 4'hF;
    chk("rnd_result", out_data, 32'hDEAD_BEEF ^ mul_ref(8'hA5, m_ref));
    for (int c = 0; c < 5; c++) step();
    rnd_valid = 1'b0; req_valid = '0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    cfg_we = 1'b1; cfg_M = rand_m(); req_valid = 4'b0001; req_data[0] = $urandom;
    step();
    cfg_we = 1'b0; req_valid = '0; rnd_valid = 1'b1; rnd_data = 8'h3C;
    step();
    rnd_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    req_valid = 4'b0010; req_data[1] = $urandom;
    step();
    req_valid = '0; rnd_valid = 1'b1; rnd_data = 8'hFF;
    step();
    rnd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cnt", tx_cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    req_valid = 4'hF;
    step();
    req_valid = '0; rnd_valid = 1'b1;
    chk("rst_ptr_grant", out_id, 2'd0);
    step();
    rnd_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
